pc_fetch_seq: RTL

Program-counter and instruction-fetch sequencer for the multicycle datapath. Sits directly downstream of the branch-offset shifter: it consumes the already-shifted 32-bit branch offset and resolves the next PC (sequential, branch, or jump-register). It also drives the request/acknowledge handshake to instruction memory and presents each fetched instruction to decode.

---
 rtl/pc_fetch_seq.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/pc_fetch_seq.sv
// Program-counter and instruction-fetch sequencer: fetch handshake, issue to decode, next-PC resolve.
// Optional misaligned-next-PC trap enabled by defining PC_MISALIGN_TRAP_EN.
module pc_fetch_seq #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] TRAP_PC  = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst,
   output logic        inst_valid,
   output logic [31:0] pc_out,
   output logic [31:0] pc_plus4,
   input  logic        stall,
   input  logic        br_taken,
   input  logic [31:0] br_off,
   input  logic        jr_en,
   input  logic [31:0] jr_target,
   output logic        trap,
   output logic [31:0] trap_addr
);

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_FETCH = 2'd1,
      ST_ISSUE = 2'd2,
      ST_TRAP  = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] inst_q, inst_d;
   logic [XLEN-1:0] pc_out_q, pc_out_d;
   logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
   logic            imem_req_q, imem_req_d;
   logic            inst_valid_q, inst_valid_d;
   logic [XLEN-1:0] next_pc;

`ifdef PC_MISALIGN_TRAP_EN
   logic            trap_q, trap_d;
   logic [XLEN-1:0] trap_addr_q, trap_addr_d;
`endif

   // Next-PC resolve: jump-register beats taken branch beats sequential; adds wrap.
   always_comb begin
      next_pc = pc_out_q + XLEN'(4);
      if (jr_en) begin
         next_pc = jr_target;
      end else if (br_taken) begin
         next_pc = pc_out_q + br_off;
      end
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      inst_d   = inst_q;
      pc_out_d = pc_out_q;
`ifdef PC_MISALIGN_TRAP_EN
      trap_addr_d = trap_addr_q;
`endif
      case (state_q)
         ST_BOOT: begin
            state_d = ST_FETCH;
         end
         ST_FETCH: begin
            if (imem_ack) begin
               inst_d   = imem_rdata;
               pc_out_d = pc_q;
               state_d  = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (!stall) begin
`ifdef PC_MISALIGN_TRAP_EN
               if (next_pc[1:0] != 2'b00) begin
                  trap_addr_d = next_pc;
                  state_d     = ST_TRAP;
               end else begin
                  pc_d    = next_pc;
                  state_d = ST_FETCH;
               end
`else
               pc_d    = next_pc & ALIGN_MASK;
               state_d = ST_FETCH;
`endif
            end
         end
         ST_TRAP: begin
            pc_d    = TRAP_PC;
            state_d = ST_FETCH;
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase

      // Outputs are registered against the state being entered.
      imem_req_d   = (state_d == ST_FETCH);
      inst_valid_d = (state_d == ST_ISSUE);
      pc_plus4_d   = pc_out_d + XLEN'(4);
`ifdef PC_MISALIGN_TRAP_EN
      trap_d = (state_d == ST_TRAP);
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_BOOT;
         pc_q         <= RESET_PC;
         inst_q       <= '0;
         pc_out_q     <= RESET_PC;
         pc_plus4_q   <= RESET_PC + XLEN'(4);
         imem_req_q   <= 1'b0;
         inst_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         inst_q       <= inst_d;
         pc_out_q     <= pc_out_d;
         pc_plus4_q   <= pc_plus4_d;
         imem_req_q   <= imem_req_d;
         inst_valid_q <= inst_valid_d;
      end
   end

`ifdef PC_MISALIGN_TRAP_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         trap_q      <= 1'b0;
         trap_addr_q <= '0;
      end else begin
         trap_q      <= trap_d;
         trap_addr_q <= trap_addr_d;
      end
   end

   assign trap      = trap_q;
   assign trap_addr = trap_addr_q;
`else
   assign trap      = 1'b0;
   assign trap_addr = '0;
`endif

   assign imem_req   = imem_req_q;
   assign imem_addr  = pc_q;
   assign inst       = inst_q;
   assign inst_valid = inst_valid_q;
   assign pc_out     = pc_out_q;
   assign pc_plus4   = pc_plus4_q;

endmodule
